// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and acceptance helper for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_SHL  = 4'h2;
    localparam logic [3:0] OP_SHR  = 4'h3;
    localparam logic [3:0] OP_CMP  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NAND = 4'h8;
    localparam logic [3:0] OP_NOR  = 4'h9;
    localparam logic [3:0] OP_XNOR = 4'hA;
    localparam logic [3:0] OP_NOT  = 4'hB;
    localparam logic [3:0] OP_NEG  = 4'hC;
    localparam logic [3:0] OP_PASS = 4'hD;
    localparam logic [3:0] OP_SWAP = 4'hE;
    localparam logic [3:0] OP_MUL  = 4'hF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // The accepting edge already performs the first iterative step, so only
    // work that needs more than one step has to pass through BUSY.
    function automatic logic is_multicycle(input logic [3:0] op, input logic [31:0] k);
        return (op == OP_MUL) || (((op == OP_SHL) || (op == OP_SHR)) && (k > 32'd1));
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle datapath: every non-iterative opcode plus its status flags.
module alu_comb import alu_pkg::*; #(
    parameter int WIDTH      = 8,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y2,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] sum_w;
    logic [WIDTH:0] diff_w;
    logic           a_gt_b;
    logic           a_lt_b;

    assign sum_w  = {1'b0, a} + {1'b0, b};
    assign diff_w = {1'b0, a} - {1'b0, b};

    always_comb begin
        if (SIGNED_CMP) begin
            a_gt_b = $signed(a) > $signed(b);
            a_lt_b = $signed(a) < $signed(b);
        end else begin
            a_gt_b = a > b;
            a_lt_b = a < b;
        end
    end

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        y      = '0;
        y2     = '0;
        flag_c = 1'b0;
        flag_v = 1'b0;
        case (op)
            OP_ADD: begin
                y      = sum_w[MSB:0];
                flag_c = sum_w[WIDTH];
                flag_v = (a[MSB] == b[MSB]) && (sum_w[MSB] != a[MSB]);
            end
            OP_SUB: begin
                y      = diff_w[MSB:0];
                flag_c = diff_w[WIDTH];
                flag_v = (a[MSB] != b[MSB]) && (diff_w[MSB] != a[MSB]);
            end
            OP_SHL, OP_SHR: y = a;
            OP_CMP: begin
                if (a_gt_b)      y = {{MSB{1'b0}}, 1'b1};
                else if (a_lt_b) y = '1;
                else             y = '0;
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            OP_NEG: begin
                y      = -a;
                flag_v = (a == {1'b1, {MSB{1'b0}}});
            end
            OP_PASS: y = a;
            OP_SWAP: begin
                y  = b;
                y2 = a;
            end
            default: y = '0;
        endcase
        flag_z = (y == '0);
        flag_n = y[MSB];
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: handshaked FSM, iterative shift / shift-add multiply and held result registers.
module alu_seq import alu_pkg::*; #(
    parameter int WIDTH      = 8,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y2,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;
    localparam logic [SHW:0] CNT_MUL  = (SHW + 1)'(WIDTH);
    localparam logic [SHW:0] CNT_LAST = (SHW + 1)'(2);
    localparam logic [SHW:0] CNT_ONE  = (SHW + 1)'(1);

    logic [1:0]       state_q, state_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] y2_q, y2_d;
    logic             c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;

    logic [WIDTH-1:0] comb_y, comb_y2;
    logic             comb_c, comb_v, comb_z, comb_n;

    alu_comb #(
        .WIDTH     (WIDTH),
        .SIGNED_CMP(SIGNED_CMP)
    ) u_comb (
        .a     (a),
        .b     (b),
        .op    (op),
        .y     (comb_y),
        .y2    (comb_y2),
        .flag_c(comb_c),
        .flag_v(comb_v),
        .flag_z(comb_z),
        .flag_n(comb_n)
    );

    logic             in_idle;
    logic [SHW-1:0]   k_in;
    logic             is_shift_in;
    logic [3:0]       step_op;
    logic [WIDTH-1:0] step_hi, step_lo, step_mc;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;
    logic             nxt_c;
    logic [WIDTH:0]   add_w;
    logic             finish_step;

    assign in_idle     = (state_q == ST_IDLE);
    assign k_in        = b[SHW-1:0];
    assign is_shift_in = (op == OP_SHL) || (op == OP_SHR);

    // One iteration step; in IDLE it works straight from the inputs so the
    // accepting edge performs the first step.
    always_comb begin
        step_op = in_idle ? op : op_q;
        step_mc = in_idle ? a : mcand_q;
        step_hi = in_idle ? '0 : hi_q;
        step_lo = in_idle ? ((op == OP_MUL) ? b : a) : lo_q;
        nxt_hi  = step_hi;
        nxt_lo  = step_lo;
        nxt_c   = 1'b0;
        add_w   = {1'b0, step_hi} + (step_lo[0] ? {1'b0, step_mc} : '0);
        case (step_op)
            OP_SHL:  {nxt_c, nxt_lo} = {step_lo, 1'b0};
            OP_SHR:  {nxt_lo, nxt_c} = {1'b0, step_lo};
            OP_MUL:  {nxt_hi, nxt_lo} = {add_w, step_lo[MSB:1]};
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        mcand_d     = mcand_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        y_d         = y_q;
        y2_d        = y2_q;
        c_d         = c_q;
        v_d         = v_q;
        z_d         = z_q;
        n_d         = n_q;
        finish_step = 1'b0;

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_d    = op;
                        mcand_d = a;
                        if (is_multicycle(op, 32'(k_in))) begin
                            state_d = ST_BUSY;
                            cnt_d   = (op == OP_MUL) ? CNT_MUL : {1'b0, k_in};
                            hi_d    = nxt_hi;
                            lo_d    = nxt_lo;
                        end else if (is_shift_in && (k_in != '0)) begin
                            state_d     = ST_DONE;
                            finish_step = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                            y_d     = comb_y;
                            y2_d    = comb_y2;
                            c_d     = comb_c;
                            v_d     = comb_v;
                            z_d     = comb_z;
                            n_d     = comb_n;
                        end
                    end
                end
                ST_BUSY: begin
                    cnt_d = cnt_q - CNT_ONE;
                    hi_d  = nxt_hi;
                    lo_d  = nxt_lo;
                    if (cnt_q == CNT_LAST) begin
                        state_d     = ST_DONE;
                        finish_step = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (finish_step) begin
            y_d  = nxt_lo;
            y2_d = (step_op == OP_MUL) ? nxt_hi : '0;
            c_d  = (step_op == OP_MUL) ? (nxt_hi != '0) : nxt_c;
            v_d  = 1'b0;
            z_d  = (nxt_lo == '0);
            n_d  = nxt_lo[MSB];
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            y_q     <= '0;
            y2_q    <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            y_q     <= y_d;
            y2_q    <= y2_d;
            c_q     <= c_d;
            v_q     <= v_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

    assign in_ready  = in_idle;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_BUSY);
    assign y         = y_q;
    assign y2        = y2_q;
    assign flag_c    = c_q;
    assign flag_v    = v_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table plus handshake, flush and reset sequences.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;
    localparam int N = 26;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, out_ready;
    logic [W-1:0] a, b;
    logic [3:0]   op;

    logic         in_ready, out_valid, busy, flag_z, flag_n, flag_c, flag_v;
    logic [W-1:0] y, y2;
    logic         s_in_ready, s_out_valid, s_busy, s_z, s_n, s_c, s_v;
    logic [W-1:0] s_y, s_y2;

    alu_seq #(.WIDTH(W), .SIGNED_CMP(1'b0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y2(y2), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
        .flag_v(flag_v), .busy(busy)
    );

    alu_seq #(.WIDTH(W), .SIGNED_CMP(1'b1)) dut_s (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .a(a), .b(b), .op(op), .out_valid(s_out_valid), .out_ready(out_ready),
        .y(s_y), .y2(s_y2), .flag_z(s_z), .flag_n(s_n), .flag_c(s_c),
        .flag_v(s_v), .busy(s_busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic [W-1:0] y2;
        logic [W-1:0] y_s;
        logic [3:0]   cvzn;
        int           lat;
    } vec_t;

    vec_t vecs [N];

    // Presents one operation and waits (bounded) for out_valid; the accepting edge counts as 1.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        op = o; a = av; b = bv; in_valid = 1'b1;
        lat = 0;
        busy_cnt = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                in_valid = 1'b0;
                a = ~av; b = ~bv; op = ~o;
            end
            if (busy) busy_cnt++;
        end while (!out_valid && lat < 40);
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat, bc, seen;

        vecs[0]  = '{OP_ADD,  8'hF0, 8'h20, 8'h10, 8'h00, 8'h10, 4'b1000, 1};
        vecs[1]  = '{OP_SUB,  8'h80, 8'h01, 8'h7F, 8'h00, 8'h7F, 4'b0100, 1};
        vecs[2]  = '{OP_CMP,  8'h80, 8'h01, 8'h01, 8'h00, 8'hFF, 4'b0000, 1};
        vecs[3]  = '{OP_SHL,  8'h81, 8'h03, 8'h08, 8'h00, 8'h08, 4'b0000, 3};
        vecs[4]  = '{OP_SHR,  8'h81, 8'h00, 8'h81, 8'h00, 8'h81, 4'b0001, 1};
        vecs[5]  = '{OP_MUL,  8'hFF, 8'hFF, 8'h01, 8'hFE, 8'h01, 4'b1000, 8};
        vecs[6]  = '{OP_SWAP, 8'h12, 8'h34, 8'h34, 8'h12, 8'h34, 4'b0000, 1};
        vecs[7]  = '{OP_AND,  8'hCA, 8'h0F, 8'h0A, 8'h00, 8'h0A, 4'b0000, 1};
        vecs[8]  = '{OP_OR,   8'hA0, 8'h05, 8'hA5, 8'h00, 8'hA5, 4'b0001, 1};
        vecs[9]  = '{OP_XOR,  8'h5A, 8'h5A, 8'h00, 8'h00, 8'h00, 4'b0010, 1};
        vecs[10] = '{OP_NAND, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 4'b0010, 1};
        vecs[11] = '{OP_NOR,  8'h00, 8'h0F, 8'hF0, 8'h00, 8'hF0, 4'b0001, 1};
        vecs[12] = '{OP_XNOR, 8'h3C, 8'h0F, 8'hCC, 8'h00, 8'hCC, 4'b0001, 1};
        vecs[13] = '{OP_NOT,  8'h55, 8'h00, 8'hAA, 8'h00, 8'hAA, 4'b0001, 1};
        vecs[14] = '{OP_NEG,  8'h80, 8'h00, 8'h80, 8'h00, 8'h80, 4'b0101, 1};
        vecs[15] = '{OP_NEG,  8'h01, 8'h00, 8'hFF, 8'h00, 8'hFF, 4'b0001, 1};
        vecs[16] = '{OP_PASS, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 4'b0010, 1};
        vecs[17] = '{OP_CMP,  8'h42, 8'h42, 8'h00, 8'h00, 8'h00, 4'b0010, 1};
        vecs[18] = '{OP_CMP,  8'h01, 8'h80, 8'hFF, 8'h00, 8'h01, 4'b0001, 1};
        vecs[19] = '{OP_SHR,  8'h81, 8'h01, 8'h40, 8'h00, 8'h40, 4'b1000, 1};
        vecs[20] = '{OP_SHL,  8'h01, 8'h07, 8'h80, 8'h00, 8'h80, 4'b0001, 7};
        vecs[21] = '{OP_ADD,  8'h7F, 8'h01, 8'h80, 8'h00, 8'h80, 4'b0101, 1};
        vecs[22] = '{OP_SUB,  8'h00, 8'h01, 8'hFF, 8'h00, 8'hFF, 4'b1001, 1};
        vecs[23] = '{OP_MUL,  8'h0F, 8'h03, 8'h2D, 8'h00, 8'h2D, 4'b0000, 8};
        vecs[24] = '{OP_SHL,  8'h81, 8'h0B, 8'h08, 8'h00, 8'h08, 4'b0000, 3};
        vecs[25] = '{OP_SHL,  8'h81, 8'h01, 8'h02, 8'h00, 8'h02, 4'b1000, 1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        #12;
        check("rst_y", y, 0);
        check("rst_y2", y2, 0);
        check("rst_flags", {flag_c, flag_v, flag_z, flag_n}, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < N; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
            check($sformatf("v%0d_y", i), y, vecs[i].y);
            check($sformatf("v%0d_y2", i), y2, vecs[i].y2);
            check($sformatf("v%0d_cvzn", i), {flag_c, flag_v, flag_z, flag_n}, vecs[i].cvzn);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy_cycles", i), bc, vecs[i].lat - 1);
            check($sformatf("v%0d_signed_y", i), s_y, vecs[i].y_s);
            check($sformatf("v%0d_in_ready_done", i), in_ready, 0);
            take();
            check($sformatf("v%0d_in_ready_after", i), in_ready, 1);
        end

        // Backpressure: result held, new requests ignored until the handshake.
        issue(OP_ADD, 8'h10, 8'h22, lat, bc);
        check("bp_first_y", y, 8'h32);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op = OP_SUB; a = 8'hFF; b = 8'(i);
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_y", i), y, 8'h32);
            check($sformatf("bp%0d_flags", i), {flag_c, flag_v, flag_z, flag_n}, 0);
            check($sformatf("bp%0d_in_ready", i), in_ready, 0);
            check($sformatf("bp%0d_out_valid", i), out_valid, 1);
        end
        in_valid = 1'b0;
        take();
        check("bp_in_ready_after", in_ready, 1);
        check("bp_out_valid_after", out_valid, 0);
        issue(OP_ADD, 8'h01, 8'h02, lat, bc);
        check("bp_resume_y", y, 8'h03);
        check("bp_resume_latency", lat, 1);
        take();

        // Flush on the fourth MUL cycle: back to IDLE, no result emitted, outputs retained.
        @(negedge clk);
        op = OP_MUL; a = 8'h0F; b = 8'h03; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_out_valid", out_valid, 0);
        check("flush_y_kept", y, 8'h03);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush_no_result", seen, 0);

        // Flush in IDLE blocks acceptance for that cycle only.
        @(negedge clk);
        op = OP_ADD; a = 8'h01; b = 8'h01; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        check("flush_idle_out_valid", out_valid, 0);
        check("flush_idle_in_ready", in_ready, 1);
        flush = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("flush_idle_then_accept", out_valid, 1);
        check("flush_idle_then_y", y, 8'h02);
        take();

        // Asynchronous reset in the middle of a long shift.
        @(negedge clk);
        op = OP_SHL; a = 8'h01; b = 8'h07; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_busy_before", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_y", y, 0);
        check("rst_mid_y2", y2, 0);
        check("rst_mid_flags", {flag_c, flag_v, flag_z, flag_n}, 0);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        issue(OP_ADD, 8'h05, 8'h06, lat, bc);
        check("post_rst_y", y, 8'h0B);
        check("post_rst_latency", lat, 1);
        take();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, sequential successor to the team's 8-bit combinational ALU.
- Keeps the same 4-bit opcode map. Adds:
  - a configurable data width;
  - valid/ready handshakes on the input and output sides;
  - status flags;
  - multi-cycle variable shifts and a shift-add multiply;
  - a second result word, so SWAP produces both operands without driving an input.
- Sits between the operand/switch registers and the result display/register file.

Parameters:
- WIDTH, 8: datapath width. Must be a power of two and ≥4.
- SIGNED_CMP, 0: CMP compares as two's complement when 1, unsigned when 0.
- SHW, $clog2(WIDTH): derived localparam; width of the shift amount.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort; returns the block to IDLE
- in_valid  in  1  operands and op presented
- in_ready  out  1  block can accept; high only in IDLE
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  4  opcode
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts the result
- y  out  WIDTH  primary result
- y2  out  WIDTH  secondary result: MUL high half, SWAP A, otherwise 0
- flag_z  out  1  y == 0
- flag_n  out  1  y[WIDTH-1]
- flag_c  out  1  carry / borrow / shifted-out bit / MUL overflow
- flag_v  out  1  signed overflow
- busy  out  1  state == BUSY

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; y, y2, all flags, out_valid and busy = 0.
  - in_ready=1 (it is decoded from state).
- States:
  - IDLE: accept when in_valid && in_ready, then capture a, b, op.
    - Single-cycle op → DONE.
    - SHL/SHR with amount k>0 → BUSY, cnt=k.
    - MUL → BUSY, cnt=WIDTH.
  - BUSY: one shift or add-shift step per cycle; cnt decrements. When cnt reaches 1, the step completes, results/flags are registered, and the state moves to DONE.
  - DONE: out_valid=1. y, y2 and flags are held stable until out_ready=1; on that edge → IDLE.
- Latency, counted from the accepting edge to the edge that sets out_valid:
  - single-cycle ops: 1;
  - shifts: max(1, k);
  - MUL: WIDTH.
- Throughput: no overlap. in_ready is low in BUSY and DONE. Back-to-back single-cycle ops issue every 2 cycles minimum.
- Opcodes:
  - 0000 ADD: y=a+b; c=carry out; v=signed overflow.
  - 0001 SUB: y=a-b; c=borrow (a<b unsigned); v=signed overflow.
  - 0010 SHL: shift left by k=b[SHW-1:0], 1 bit/cycle; c=last bit shifted out.
  - 0011 SHR: logical shift right by k; c=last bit shifted out. k=0 → y=a, c=0, latency 1.
  - 0100 CMP: y=0 if equal, 1 if a>b, all-ones if a<b. Signedness per SIGNED_CMP.
  - 0101 AND, 0110 OR, 0111 XOR, 1000 NAND, 1001 NOR, 1010 XNOR, 1011 NOT a.
  - 1100 NEG: y=-a; v=1 only when a = 100…0.
  - 1101 PASS: y=a.
  - 1110 SWAP: y=b, y2=a.
  - 1111 MUL: unsigned shift-add. {y2,y}=a*b; c=(y2!=0).
- c and v are 0 for every op not listed with them. z and n always derive from y.
- flush:
  - Takes priority over every other event in every state: next state IDLE, out_valid=0.
  - y, y2 and flags keep their last values; no result is emitted.
  - flush in IDLE is a no-op and also blocks acceptance that cycle.
- out_ready while out_valid=0 is ignored.
- Inputs a, b and op changing during BUSY have no effect; operands are captured at acceptance.
- rst asserted mid-BUSY or in DONE: immediate return to reset values; the pending result is lost.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_ADD…OP_MUL);
  - state encoding (ST_IDLE, ST_BUSY, ST_DONE);
  - the function is_multicycle(op, k).
- Sub-module alu_comb: purely combinational single-cycle datapath covering all non-iterative ops plus flags, parametrised by WIDTH and SIGNED_CMP.
- alu_seq owns the FSM, the counter, the shift/MUL accumulator and the output registers.

Test Plan:
- WIDTH=8, ADD a=0xF0 b=0x20 → y=0x10, c=1, v=0, z=0; out_valid one edge after acceptance.
- SUB a=0x80 b=0x01 → y=0x7F, v=1, c=0, n=0. Then CMP a=0x80 b=0x01 → y=0x01 with SIGNED_CMP=0, y=0xFF with SIGNED_CMP=1.
- SHL a=0x81 b=3 → y=0x08, c=0; out_valid 3 edges after acceptance; busy high for 2 cycles; in_ready low until the output is taken. SHR a=0x81 b=0 → y=0x81, latency 1.
- MUL a=0xFF b=0xFF → y=0x01, y2=0xFE, c=1, out_valid 8 edges after acceptance. SWAP a=0x12 b=0x34 → y=0x34, y2=0x12.
- Backpressure: hold out_ready=0 for 5 cycles after ADD → y and flags stable, in_ready=0; in_valid pulses are ignored until the handshake, and acceptance resumes in IDLE.
- flush at cycle 4 of MUL → IDLE next edge, no out_valid. rst pulse mid-SHL (a=0x01 b=7) → all outputs 0, in_ready=1 asynchronously; the next ADD completes normally.
